// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_pkg;

  localparam int unsigned ImemDepthDefault = 64;
  localparam logic [31:0] ImemOorData      = 32'h0000_0000;

  typedef enum logic [2:0] {
    StIdle,
    StCount,
    StData,
    StCsum,
    StDone,
    StErr
  } imem_state_e;

endpackage

// File: rtl/imem_ram.sv
// DEPTH x 32 instruction storage: synchronous write, asynchronous read, no reset.
module imem_ram
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH = ImemDepthDefault,
  parameter int unsigned IDX_W = 6
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [31:0]      wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// Byte-stream instruction loader: count byte, then little-endian words, held core meanwhile.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH  = ImemDepthDefault,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [31:0]       rd_data,
  output logic              core_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [7:0]        words_loaded
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  imem_state_e state_q, state_d;
  logic        ready_q, ready_d;
  logic        hold_q, hold_d;
  logic        err_q, err_d;
  logic [7:0]  wl_q, wl_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  bidx_q, bidx_d;
  logic [23:0] word_q, word_d;
  logic        we;
  logic        accept;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  assign accept = byte_valid && ready_q;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    err_d   = err_q;
    wl_d    = wl_q;
    cnt_d   = cnt_q;
    bidx_d  = bidx_q;
    word_d  = word_q;
    we      = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (load_start) begin
          state_d = StCount;
          hold_d  = 1'b1;
          err_d   = 1'b0;
          wl_d    = 8'd0;
        end
      end
      StCount: begin
        if (accept) begin
          if ((byte_in == 8'd0) || ({24'd0, byte_in} > DEPTH)) begin
            state_d = StErr;
          end else begin
            state_d = StData;
            cnt_d   = byte_in;
            bidx_d  = 2'd0;
            wl_d    = 8'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_d  = 8'd0;
`endif
          end
        end
      end
      StData: begin
        if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ byte_in;
`endif
          bidx_d = bidx_q + 2'd1;
          unique case (bidx_q)
            2'd0: word_d[7:0]   = byte_in;
            2'd1: word_d[15:8]  = byte_in;
            2'd2: word_d[23:16] = byte_in;
            default: begin
              we   = 1'b1;
              wl_d = wl_q + 8'd1;
              if ((wl_q + 8'd1) == cnt_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state_d = StCsum;
`else
                state_d = StDone;
`endif
              end
            end
          endcase
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      StCsum: begin
        if (accept) begin
          state_d = (byte_in == csum_q) ? StDone : StErr;
        end
      end
`endif
      StDone: begin
        hold_d  = 1'b0;
        state_d = StIdle;
      end
      StErr: begin
        hold_d  = 1'b0;
        err_d   = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Ready is registered off the next state so it is valid on entry to a byte-taking state.
  assign ready_d = (state_d == StCount) || (state_d == StData) || (state_d == StCsum);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      ready_q <= 1'b0;
      hold_q  <= 1'b0;
      err_q   <= 1'b0;
      wl_q    <= 8'd0;
      cnt_q   <= 8'd0;
      bidx_q  <= 2'd0;
      word_q  <= 24'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
      wl_q    <= wl_d;
      cnt_q   <= cnt_d;
      bidx_q  <= bidx_d;
      word_q  <= word_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  logic [31:0] rd_idx;
  logic [31:0] ram_rdata;
  logic [1:0]  unused_rd_lsbs;

  assign rd_idx         = 32'(rd_addr[ADDR_W-1:2]);
  assign unused_rd_lsbs = rd_addr[1:0];

  imem_ram #(
    .DEPTH (DEPTH),
    .IDX_W (IdxW)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (wl_q[IdxW-1:0]),
    .wdata ({byte_in, word_q}),
    .raddr (rd_idx[IdxW-1:0]),
    .rdata (ram_rdata)
  );

  assign rd_data      = (rd_idx < DEPTH) ? ram_rdata : ImemOorData;
  assign byte_ready   = ready_q;
  assign core_hold    = hold_q;
  assign load_done    = (state_q == StDone);
  assign load_err     = err_q;
  assign words_loaded = wl_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: stream-position model plus directed literal checks.
// Honours IMEM_LOADER_CHECKSUM_EN the same way as the design.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [7:0]  rd_addr;
  logic [31:0] rd_data;
  logic        core_hold;
  logic        load_done;
  logic        load_err;
  logic [7:0]  words_loaded;

  logic        byte_ready2, core_hold2, load_done2, load_err2;
  logic [7:0]  rd_addr2;
  logic [31:0] rd_data2;
  logic [7:0]  words_loaded2;

  always #5 clk = ~clk;

  imem_loader #(.DEPTH(64), .ADDR_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .load_start   (load_start),
    .byte_in      (byte_in),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .core_hold    (core_hold),
    .load_done    (load_done),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  // Narrow instance sharing the stream; used only for out-of-range read checks.
  imem_loader #(.DEPTH(32), .ADDR_W(8)) dut32 (
    .clk          (clk),
    .reset        (reset),
    .load_start   (load_start),
    .byte_in      (byte_in),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready2),
    .rd_addr      (rd_addr2),
    .rd_data      (rd_data2),
    .core_hold    (core_hold2),
    .load_done    (load_done2),
    .load_err     (load_err2),
    .words_loaded (words_loaded2)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam int CsBytes = 1;
`else
  localparam int CsBytes = 0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  bit check_en = 0;
  bit rd_pin   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: tracks stream position within a load rather than controller states.
  logic [31:0] m_mem [64];
  bit          m_known [64];
  bit          m_hold, m_ready, m_done, m_err, m_err_next;
  int          m_words, m_pos, m_n, m_total;
  logic [7:0]  m_xor;
  logic [31:0] m_acc;

  task automatic model_reset();
    m_hold = 0; m_ready = 0; m_done = 0; m_err = 0; m_err_next = 0;
    m_words = 0; m_pos = 0;
  endtask

  task automatic model_step();
    bit idle;
    bit acc;
    int k;
    idle = !m_hold;
    acc  = byte_valid && m_ready;
    if (m_done) begin m_done = 0; m_hold = 0; end
    if (m_err_next) begin m_err_next = 0; m_err = 1; m_hold = 0; end
    if (idle) begin
      if (load_start) begin
        m_hold = 1; m_err = 0; m_words = 0; m_pos = 0; m_ready = 1; m_xor = 8'h00;
      end
    end else if (acc) begin
      if (m_pos == 0) begin
        m_n     = int'(byte_in);
        m_total = 1 + 4 * m_n + CsBytes;
        if (m_n == 0 || m_n > 64) begin m_ready = 0; m_err_next = 1; end
      end else if (m_pos <= 4 * m_n) begin
        k = (m_pos - 1) % 4;
        m_acc[8*k +: 8] = byte_in;
        m_xor = m_xor ^ byte_in;
        if (k == 3) begin
          m_mem[m_words]   = m_acc;
          m_known[m_words] = 1;
          m_words++;
        end
      end else if (byte_in != m_xor) begin
        m_ready = 0; m_err_next = 1;
      end
      m_pos++;
      if (m_pos == m_total && !m_err_next) begin m_ready = 0; m_done = 1; end
    end
  endtask

  initial begin
    foreach (m_known[i]) m_known[i] = 0;
    model_reset();
  end

  always @(posedge clk) if (!reset) model_step();

  always @(negedge clk) begin
    if (check_en) begin
      chk("byte_ready", {31'b0, byte_ready}, {31'b0, m_ready});
      chk("core_hold", {31'b0, core_hold}, {31'b0, m_hold});
      chk("load_done", {31'b0, load_done}, {31'b0, m_done});
      chk("load_err", {31'b0, load_err}, {31'b0, m_err});
      chk("words_loaded", {24'b0, words_loaded}, 32'(m_words));
      if (m_known[rd_addr[7:2]]) chk("rd_data", rd_data, m_mem[rd_addr[7:2]]);
      if (load_done === 1'b1) done_cnt++;
    end
  end

  // Sweep the read address each cycle unless the main sequence pins it.
  initial forever begin
    @(posedge clk); #2;
    if (!rd_pin) rd_addr = rd_addr + 8'd5;
  end

  logic [31:0] wq[$];
  bit          cs_force = 0;
  logic [7:0]  cs_val   = 8'h00;

  task automatic start();
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
    chk("hold_after_start", {31'b0, core_hold}, 32'd1);
    chk("err_cleared_on_start", {31'b0, load_err}, 32'd0);
  endtask

  task automatic run_load(input bit gap, input int limit, input int cnt);
    logic [7:0] s[$];
    logic [7:0] x;
    bit         acc;
    int         t;
    x = 8'h00;
    s.push_back((cnt < 0) ? 8'(wq.size()) : 8'(cnt));
    foreach (wq[i]) for (int k = 0; k < 4; k++) begin
      s.push_back(wq[i][8*k +: 8]);
      x = x ^ wq[i][8*k +: 8];
    end
    if (CsBytes == 1) s.push_back(cs_force ? cs_val : x);
    start();
    for (int i = 0; i < s.size(); i++) begin
      if (limit >= 0 && i >= limit) break;
      byte_in = s[i];
      byte_valid = 1'b1;
      t = 0;
      do begin
        acc = byte_ready;
        @(posedge clk); #1;
        t++;
      end while (!acc && t < 50);
      if (!acc) chk("accept_timeout", 32'd0, 32'd1);
      byte_valid = 1'b0;
      byte_in = 8'hAA;
      if (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic rd_check(input string nm, input logic [7:0] a, input logic [31:0] exp);
    @(posedge clk); #1;
    rd_pin = 1;
    rd_addr = a;
    #1;
    chk(nm, rd_data, exp);
  endtask

  task automatic rd2_check(input string nm, input logic [7:0] a, input logic [31:0] exp);
    @(posedge clk); #1;
    rd_addr2 = a;
    #1;
    chk(nm, rd_data2, exp);
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_prog(input string tag);
    rd_check({tag, "_w0"}, 8'h00, 32'h00450693);
    rd_check({tag, "_w1"}, 8'h04, 32'h00100713);
    rd_check({tag, "_w2"}, 8'h08, 32'h00b76463);
    rd_check({tag, "_w1_lsb"}, 8'h05, 32'h00100713);
    rd_pin = 0;
  endtask

  int d0;

  initial begin
    reset = 1'b1; load_start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
    rd_addr = 8'h00; rd_addr2 = 8'h00;
    repeat (2) @(posedge clk); #1;
    chk("rst_ready", {31'b0, byte_ready}, 32'd0);
    chk("rst_hold", {31'b0, core_hold}, 32'd0);
    chk("rst_done", {31'b0, load_done}, 32'd0);
    chk("rst_err", {31'b0, load_err}, 32'd0);
    chk("rst_words", {24'b0, words_loaded}, 32'd0);
    check_en = 1;
    reset = 1'b0;

    // Valid bytes while idle must be ignored.
    byte_valid = 1'b1; byte_in = 8'h03;
    repeat (3) @(posedge clk); #1;
    byte_valid = 1'b0;
    chk("idle_ignore_words", {24'b0, words_loaded}, 32'd0);

    wq = '{32'h00450693, 32'h00100713, 32'h00b76463};
    d0 = done_cnt;
    run_load(0, -1, -1);
    settle();
    chk("n3_done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("n3_words", {24'b0, words_loaded}, 32'd3);
    chk("n3_hold_end", {31'b0, core_hold}, 32'd0);
    check_prog("n3");

    wq.delete();
    run_load(0, -1, 0);
    settle();
    chk("cnt0_err", {31'b0, load_err}, 32'd1);
    chk("cnt0_hold", {31'b0, core_hold}, 32'd0);
    chk("cnt0_words", {24'b0, words_loaded}, 32'd0);
    run_load(0, -1, 8'h41);
    settle();
    chk("cnt41_err", {31'b0, load_err}, 32'd1);
    chk("cnt41_hold", {31'b0, core_hold}, 32'd0);

    wq = '{32'h00450693, 32'h00100713, 32'h00b76463};
    d0 = done_cnt;
    run_load(1, -1, -1);
    settle();
    chk("gap_done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("gap_err", {31'b0, load_err}, 32'd0);
    check_prog("gap");

    // Reset after 6 data bytes of a different program.
    wq = '{32'h11223344, 32'h55667788, 32'h99aabbcc};
    run_load(0, 7, -1);
    reset = 1'b1;
    model_reset();
    #1;
    chk("midrst_ready", {31'b0, byte_ready}, 32'd0);
    chk("midrst_hold", {31'b0, core_hold}, 32'd0);
    chk("midrst_words", {24'b0, words_loaded}, 32'd0);
    repeat (2) @(posedge clk); #1;
    reset = 1'b0;
    rd_check("midrst_w0_kept", 8'h00, 32'h11223344);
    rd_check("midrst_w1_old", 8'h04, 32'h00100713);
    rd_pin = 0;

    wq = '{32'h00450693, 32'h00100713, 32'h00b76463};
    run_load(0, -1, -1);
    settle();
    chk("fresh_words", {24'b0, words_loaded}, 32'd3);
    check_prog("fresh");

    rd2_check("d32_oor_fc", 8'hFC, 32'h0);
    rd2_check("d32_oor_80", 8'h80, 32'h0);
    rd2_check("d32_w1", 8'h04, 32'h00100713);

`ifdef IMEM_LOADER_CHECKSUM_EN
    wq = '{32'h00008067};
    cs_force = 1; cs_val = 8'h00;
    run_load(0, -1, -1);
    settle();
    chk("cs_bad_err", {31'b0, load_err}, 32'd1);
    rd_check("cs_bad_word_kept", 8'h00, 32'h00008067);
    rd_pin = 0;
    cs_val = 8'hE7;
    d0 = done_cnt;
    run_load(0, -1, -1);
    settle();
    chk("cs_good_done", 32'(done_cnt - d0), 32'd1);
    chk("cs_good_err", {31'b0, load_err}, 32'd0);
    cs_force = 0;
`endif

    check_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory. Accepts a byte stream from a host or debug link, assembles little-endian 32-bit instruction words, and writes them at consecutive byte addresses 0x00, 0x04, 0x08, …
- Exposes the same combinational read port the fetch path uses: byte address in, 32-bit instruction out.
- Holds the core (via core_hold, ORed into the program counter reset) while a load is in progress.

Parameters:
- DEPTH, 64, number of 32-bit instruction words stored.
- ADDR_W, 8, width of the byte address on the read port; word index = rd_addr[ADDR_W-1:2].

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- load_start  input  1  single-cycle request to begin a load; sampled only in IDLE.
- byte_in  input  8  stream data byte.
- byte_valid  input  1  byte_in is valid.
- byte_ready  output  1  loader can accept a byte this cycle.
- rd_addr  input  ADDR_W  fetch byte address.
- rd_data  output  32  instruction at rd_addr (combinational).
- core_hold  output  1  high while loading; core stays in reset.
- load_done  output  1  one-cycle pulse on successful completion.
- load_err  output  1  sticky error flag; cleared by the next accepted load_start or by reset.
- words_loaded  output  8  count of words written in the current or last load.

Behaviour:
- Reset (async, immediate) values:
  - State = IDLE.
  - byte_ready = 0, core_hold = 0, load_done = 0, load_err = 0, words_loaded = 0.
  - Storage contents are NOT cleared by reset.
- Handshake: a byte is accepted on a rising edge with byte_valid && byte_ready. byte_ready is a registered function of state and is high only in COUNT, DATA and CSUM.
- IDLE:
  - load_start = 1 → COUNT. Same edge: core_hold ← 1, load_err ← 0, words_loaded ← 0.
  - byte_valid is ignored in IDLE.
- COUNT: first accepted byte is word count N.
  - N == 0 or N > DEPTH → ERR.
  - Otherwise latch N, clear byte index and write pointer → DATA.
- DATA: bytes arrive least-significant first.
  - Byte k of a word goes to bits [8k+7:8k].
  - On the edge accepting byte 3, the full word is written at word index wptr, wptr increments, and words_loaded increments.
  - The new word is visible on rd_data from the following cycle.
  - After word N is written → DONE, or → CSUM when the checksum feature is enabled.
- DONE: lasts one cycle.
  - load_done = 1, core_hold drops to 0 on exit.
  - → IDLE.
- ERR: lasts one cycle.
  - load_err ← 1, core_hold ← 0.
  - → IDLE.
- Read port: rd_data = mem[rd_addr[ADDR_W-1:2]] when that index < DEPTH, else 32'h00000000. rd_addr[1:0] is ignored.
- Boundaries:
  - load_start while not in IDLE is ignored.
  - Gaps in byte_valid stall the FSM with no timeout.
  - Reset mid-load returns to IDLE immediately. Words already written stay written; the partial word is discarded.
  - Writes and reads to the same index in the same cycle: rd_data shows the old word until the edge.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined: after word N, the FSM enters CSUM and accepts one extra byte.
  - Byte equals XOR of all 4N data bytes → DONE.
  - Otherwise → ERR; words written so far remain.
- Undefined: no CSUM state. DONE follows word N directly, and the stream carries exactly 1 + 4N bytes.

Decomposition:
- Package imem_pkg holds:
  - state encoding: IDLE, COUNT, DATA, CSUM, DONE, ERR;
  - the default DEPTH constant;
  - the out-of-range read value (32'h0).
- One sub-module, imem_ram: DEPTH×32 array with synchronous write and asynchronous read, instantiated by imem_loader.

Test Plan:
- Load N=3 with words 0x00450693, 0x00100713, 0x00b76463 as bytes 03 93 06 45 00 13 07 10 00 63 64 b7 00 → rd_addr 0x00/0x04/0x08 return those words; load_done pulses once; words_loaded = 3; core_hold high from the edge after load_start until after DONE.
- Same load with byte_valid toggling every other cycle → identical memory contents; byte_ready never high in IDLE.
- Count byte 0x00, then a separate load with count 0x41 (DEPTH=64) → load_err = 1, no writes, core_hold = 0; next load_start clears load_err.
- Assert reset after 6 data bytes of a 3-word load → outputs return to reset values immediately; word 0 retained; word 1 not written; a fresh full load then succeeds.
- rd_addr = 0xFC with DEPTH=32 → rd_data = 0; rd_addr = 0x05 returns the word at 0x04.
- With IMEM_LOADER_CHECKSUM_EN: 1-word load of 0x00008067 with checksum 0xE7 → load_done. Same load with checksum 0x00 → load_err, and the word is still readable at 0x00.
